ra_pq: RTL
==========

# ra_pq

Register-array priority queue: the responder side of the `pq_if` insert/remove handshake driven by the queue benches, and an alternative to the shift-register queue. It holds up to `DEPTH` key/value pairs in an unordered slot array with per-slot valid bits. A registered argmin search always presents the highest-priority (smallest key) entry on the output port.

## Interface
Parameters:
- `DEPTH`, 8: number of storage slots, ≥2.
- `KW`, 4: key width; taken from `pq_pkg`, overridable.
- `VW`, 4: value width; taken from `pq_pkg`, overridable.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `idata`  in  KW+VW  insert pair, `{key,value}`, key in the MSBs.
- `ivalid`  in  1  insert request.
- `irdy`  out  1  ready to accept an insert.
- `odata`  out  KW+VW  current head pair `{key,value}`.
- `ovalid`  out  1  `odata` holds a valid head.
- `ordy`  in  1  consumer removes the head.
- `count`  out  $clog2(DEPTH+1)  number of stored entries.

## Operation
- Priority rule: the smallest key is removed first.
  - Among equal keys, the lowest slot index wins.
  - Order among equal keys is therefore not FIFO.
- Insert fires when `ivalid && irdy`.
  - The pair is written into the lowest-index slot whose valid bit is 0 in the current state.
  - That slot's valid bit is set.
- Remove fires when `ovalid && ordy`.
  - The valid bit of the slot at the registered `head_idx` is cleared.
  - Data in that slot is don't-care afterwards.
- `irdy = (count != DEPTH)`.
  - This is registered-state combinational only; it does not depend on `ivalid` or `ordy`.
  - When full, an insert is refused even if a remove fires the same cycle.
- Simultaneous insert and remove:
  - Both fire.
  - The slot freed this cycle is not reused this cycle.
  - `count` is unchanged.
  - The new pair may itself become the head if its key is smallest.
- Head update:
  - `odata`, `ovalid` and `head_idx` are registers.
  - Each cycle they are loaded with the argmin over the next-state array, i.e. after this cycle's insert and/or remove are applied.
  - If the next-state array is empty, `ovalid` is 0 and `odata` holds its last value.
- `count` arithmetic: +1 on insert only, −1 on remove only; it never wraps.
- `ordy` with `ovalid=0` and `ivalid` with `irdy=0` are ignored, with no state change.
- Reset (any time, including mid-operation):
  - All valid bits, `count`, `ovalid`, `head_idx` and `odata` go to 0.
  - `irdy` is 1 once `rst_n` is low.
  - No request is accepted while `rst_n` is low.

## Timing
- Insert into an empty queue at edge N: `ovalid=1` and `odata`=that pair after edge N (latency 1).
- Remove at edge N: the next head is visible after edge N, so back-to-back removes sustain 1 entry per cycle.
- Insert of a smaller key at edge N: `odata` changes after edge N.
  - A remove sampled at edge N still removes the old head.
- `irdy` falls after the edge that makes `count==DEPTH` and rises after the first remove.
- The argmin path is a single-cycle combinational tree, depth ⌈log2 DEPTH⌉ compare stages.

## Structure
- `pq_pkg` holds:
  - `KW`, `VW`;
  - `typedef struct packed {logic [KW-1:0] key; logic [VW-1:0] value;} kvpair_t`;
  - the `pq_min_find` result struct (`kvpair_t` plus index plus found bit).
- Sub-module `pq_min_find`:
  - purely combinational, parameterised on `DEPTH`;
  - inputs: slot array and valid vector;
  - outputs: min pair, its index and an any-valid flag;
  - ties resolve to the lower index.
- `ra_pq` contains the slot array, valid vector, free-slot priority encoder, `count`, and the head registers.

## Test plan
- Reset then idle: `ovalid=0`, `irdy=1`, `count=0`.
  - Assert `ordy` with the queue empty → no change.
  - Pull `rst_n` low mid-stream → all outputs cleared.
- Insert {4,14}, {12,12}, {3,13}, {1,11} on consecutive cycles:
  - head sequence after each edge: {4,14}, {4,14}, {3,13}, {1,11};
  - then hold `ordy=1` for 4 cycles → removes {1,11}, {3,13}, {4,14}, {12,12}, then `ovalid=0`.
- Fill to `DEPTH`=8 with keys 8..1 descending:
  - `irdy=0` and `count=8`;
  - an extra insert with `ordy=1` in the same cycle → the remove fires, the insert is refused, `count=7`.
- Queue holding {5,15}; in one cycle insert {1,11} and assert `ordy`:
  - {5,15} is removed;
  - head becomes {1,11}, `count` stays 1.
- Equal keys: insert {6,1} then {6,2} → removals return {6,1} then {6,2} (slot order).
  - After freeing slot 0 and refilling it with {6,3}, the next removal returns {6,3}, since the lowest index wins.

Source files
------------

// File: rtl/pq_pkg.sv
// Shared widths and types for the priority-queue family.
// kvpair_t packs key above value so a plain vector compare orders by key first.
package pq_pkg;

   localparam int unsigned KW        = 4;
   localparam int unsigned VW        = 4;
   localparam int unsigned IDX_MAX_W = 8;

   typedef struct packed {
      logic [KW-1:0] key;
      logic [VW-1:0] value;
   } kvpair_t;

   typedef struct packed {
      kvpair_t              pair;
      logic [IDX_MAX_W-1:0] idx;
      logic                 found;
   } min_res_t;

endpackage

// File: rtl/pq_min_find.sv
// Combinational argmin over a slot array with valid bits.
// Balanced compare tree; ties resolve to the lower slot index.
module pq_min_find
   import pq_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned KW    = pq_pkg::KW,
   parameter int unsigned VW    = pq_pkg::VW
) (
   input  logic [KW+VW-1:0]         i_slots [DEPTH],
   input  logic [DEPTH-1:0]         i_valid,
   output logic [KW+VW-1:0]         o_min,
   output logic [$clog2(DEPTH)-1:0] o_idx,
   output logic                     o_found
);

   localparam int unsigned IDXW = $clog2(DEPTH);
   localparam int unsigned PW   = KW + VW;

   // Level IDXW holds the (power-of-two padded) leaves, level 0 the root.
   for (genvar l = 0; l <= IDXW; l++) begin : g_lvl
      localparam int unsigned N = 1 << l;
      logic [N-1:0]    w_v;
      logic [KW-1:0]   w_k [N];
      logic [VW-1:0]   w_d [N];
      logic [IDXW-1:0] w_i [N];

      for (genvar n = 0; n < N; n++) begin : g_node
         if (l == IDXW) begin : g_leaf
            if (n < DEPTH) begin : g_real
               assign w_v[n] = i_valid[n];
               assign w_k[n] = i_slots[n][PW-1 -: KW];
               assign w_d[n] = i_slots[n][VW-1:0];
               assign w_i[n] = IDXW'(n);
            end else begin : g_pad
               assign w_v[n] = 1'b0;
               assign w_k[n] = '0;
               assign w_d[n] = '0;
               assign w_i[n] = '0;
            end
         end else begin : g_cmp
            logic w_left;
            // Left subtree always covers lower indices, so <= gives the tie rule.
            assign w_left = g_lvl[l+1].w_v[2*n] &&
                            (!g_lvl[l+1].w_v[2*n+1] ||
                             (g_lvl[l+1].w_k[2*n] <= g_lvl[l+1].w_k[2*n+1]));
            assign w_v[n] = g_lvl[l+1].w_v[2*n] | g_lvl[l+1].w_v[2*n+1];
            assign w_k[n] = w_left ? g_lvl[l+1].w_k[2*n] : g_lvl[l+1].w_k[2*n+1];
            assign w_d[n] = w_left ? g_lvl[l+1].w_d[2*n] : g_lvl[l+1].w_d[2*n+1];
            assign w_i[n] = w_left ? g_lvl[l+1].w_i[2*n] : g_lvl[l+1].w_i[2*n+1];
         end
      end
   end

   assign o_found = g_lvl[0].w_v[0];
   assign o_min   = {g_lvl[0].w_k[0], g_lvl[0].w_d[0]};
   assign o_idx   = g_lvl[0].w_i[0];

endmodule

// File: rtl/ra_pq.sv
// Register-array priority queue: unordered slots plus a registered argmin head.
// The head registers are loaded from the argmin of the next-state array each cycle.
module ra_pq
   import pq_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned KW    = pq_pkg::KW,
   parameter int unsigned VW    = pq_pkg::VW
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [KW+VW-1:0]           idata,
   input  logic                       ivalid,
   output logic                       irdy,
   output logic [KW+VW-1:0]           odata,
   output logic                       ovalid,
   input  logic                       ordy,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned IDXW = $clog2(DEPTH);
   localparam int unsigned CW   = $clog2(DEPTH+1);
   localparam int unsigned PW   = KW + VW;

   logic [PW-1:0]    r_slot [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [CW-1:0]    r_count;
   logic [IDXW-1:0]  r_head_idx;
   logic [PW-1:0]    r_odata;
   logic             r_ovalid;

   logic             w_irdy;
   logic             w_ins;
   logic             w_rem;
   logic [IDXW-1:0]  w_free_idx;
   logic [DEPTH-1:0] w_valid_nxt;
   logic [PW-1:0]    w_slot_nxt [DEPTH];
   logic [PW-1:0]    w_min;
   logic [IDXW-1:0]  w_min_idx;
   logic             w_found;

   assign w_irdy = (r_count != CW'(DEPTH));
   assign w_ins  = ivalid && w_irdy;
   assign w_rem  = r_ovalid && ordy;

   // Free slot comes from the current state, so a slot freed this cycle is not reused.
   always_comb begin
      w_free_idx = '0;
      for (int unsigned i = DEPTH; i > 0; i--) begin
         if (!r_valid[i-1]) begin
            w_free_idx = IDXW'(i-1);
         end
      end
   end

   always_comb begin
      w_valid_nxt = r_valid;
      if (w_rem) begin
         w_valid_nxt[r_head_idx] = 1'b0;
      end
      if (w_ins) begin
         w_valid_nxt[w_free_idx] = 1'b1;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
         w_slot_nxt[i] = r_slot[i];
      end
      if (w_ins) begin
         w_slot_nxt[w_free_idx] = idata;
      end
   end

   pq_min_find #(
      .DEPTH (DEPTH),
      .KW    (KW),
      .VW    (VW)
   ) u_min_find (
      .i_slots (w_slot_nxt),
      .i_valid (w_valid_nxt),
      .o_min   (w_min),
      .o_idx   (w_min_idx),
      .o_found (w_found)
   );

   always_ff @(posedge clk) begin
      if (w_ins) begin
         r_slot[w_free_idx] <= idata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid    <= '0;
         r_count    <= '0;
         r_head_idx <= '0;
         r_odata    <= '0;
         r_ovalid   <= 1'b0;
      end else begin
         r_valid  <= w_valid_nxt;
         r_ovalid <= w_found;
         if (w_found) begin
            r_odata    <= w_min;
            r_head_idx <= w_min_idx;
         end
         if (w_ins && !w_rem) begin
            r_count <= r_count + 1'b1;
         end else if (w_rem && !w_ins) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign irdy   = w_irdy;
   assign odata  = r_odata;
   assign ovalid = r_ovalid;
   assign count  = r_count;

endmodule
